// File: rtl/iq_pkg.sv
// Shared constants and one-hot helpers for the issue queue.
// Helpers work on a fixed maximum width; callers zero-extend and cast back to their depth.
package iq_pkg;

  localparam int unsigned IQ_MAX_DEPTH = 32'd64;
  localparam int unsigned IQ_IDX_W     = 32'd6;
  localparam int unsigned TAG_NULL     = 32'd0;
  localparam int unsigned SEL_LOWEST   = 32'd0;
  localparam int unsigned SEL_OLDEST   = 32'd1;

  function automatic logic [IQ_MAX_DEPTH-1:0] lowest_set(input logic [IQ_MAX_DEPTH-1:0] vec);
    logic [IQ_MAX_DEPTH-1:0] oh;
    logic                    found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < int'(IQ_MAX_DEPTH); i++) begin
      oh[i] = vec[i] & ~found;
      found = found | vec[i];
    end
    return oh;
  endfunction

  function automatic logic [IQ_IDX_W-1:0] onehot_to_idx(input logic [IQ_MAX_DEPTH-1:0] oh);
    logic [IQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(IQ_MAX_DEPTH); i++) begin
      idx = idx | (oh[i] ? IQ_IDX_W'(i) : {IQ_IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age tracker: age_r[i][j] = 1 means entry i was inserted before entry j.
// Produces a one-hot pick of the oldest entry among the ready vector.
module iq_age_matrix
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH = 32'd16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             ins_en,
  input  logic [DEPTH-1:0] ins_oh,
  input  logic             clr_en,
  input  logic [DEPTH-1:0] clr_oh,
  input  logic [DEPTH-1:0] valid_vec,
  input  logic [DEPTH-1:0] rdy_vec,
  output logic [DEPTH-1:0] oldest_oh
);

  logic [DEPTH-1:0] age_r     [DEPTH];
  logic [DEPTH-1:0] age_nxt_s [DEPTH];
  logic [DEPTH-1:0] blocked_s;

  // Next age state: a new entry is younger than every currently valid entry
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (flush) begin
          age_nxt_s[i][j] = 1'b0;
        end else if (ins_en && ins_oh[i]) begin
          age_nxt_s[i][j] = 1'b0;
        end else if (clr_en && (clr_oh[i] || clr_oh[j])) begin
          age_nxt_s[i][j] = 1'b0;
        end else if (ins_en && ins_oh[j]) begin
          age_nxt_s[i][j] = valid_vec[i];
        end else begin
          age_nxt_s[i][j] = age_r[i][j];
        end
      end
    end
  end

  // Age state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        age_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        age_r[i] <= age_nxt_s[i];
      end
    end
  end

  // An entry wins when no other ready entry is older than it
  always_comb begin
    blocked_s = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        blocked_s[i] = blocked_s[i] | (rdy_vec[j] & age_r[j][i]);
      end
    end
    oldest_oh = rdy_vec & ~blocked_s;
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions, wakes operands from writeback
// tag buses and issues one ready entry per cycle (oldest-first or lowest-index).
module issue_queue
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH     = 32'd16,
  parameter int unsigned PAYLOAD_W = 32'd157,
  parameter int unsigned TAG_W     = 32'd6,
  parameter int unsigned NUM_WB    = 32'd2,
  parameter int unsigned SEL_MODE  = 32'd1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic [TAG_W-1:0]           in_rs_tag,
  input  logic                       in_rs_rdy,
  input  logic [TAG_W-1:0]           in_rt_tag,
  input  logic                       in_rt_rdy,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [TAG_W-1:0]           out_rs_tag,
  output logic [TAG_W-1:0]           out_rt_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     rs_rdy_r;
  logic [DEPTH-1:0]     rt_rdy_r;
  logic [TAG_W-1:0]     rs_tag_r  [DEPTH];
  logic [TAG_W-1:0]     rt_tag_r  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_r [DEPTH];
  logic [CNT_W-1:0]     count_r;

  logic [NUM_WB-1:0]    bus_live_s;
  logic [DEPTH-1:0]     rs_hit_s;
  logic [DEPTH-1:0]     rt_hit_s;
  logic                 in_rs_hit_s;
  logic                 in_rt_hit_s;
  logic [DEPTH-1:0]     ready_vec_s;
  logic [DEPTH-1:0]     free_vec_s;
  logic [DEPTH-1:0]     free_oh_s;
  logic [DEPTH-1:0]     sel_oh_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 out_valid_s;
  logic                 ins_fire_s;
  logic                 iss_fire_s;

  // A bus only wakes anything when valid and carrying a non-null tag
  always_comb begin
    for (int b = 0; b < int'(NUM_WB); b++) begin
      bus_live_s[b] = wb_valid[b] & (wb_tag[b*TAG_W +: TAG_W] != TAG_W'(TAG_NULL));
    end
  end

  // Tag match of every stored operand and of the incoming operands against all buses
  always_comb begin
    rs_hit_s    = '0;
    rt_hit_s    = '0;
    in_rs_hit_s = 1'b0;
    in_rt_hit_s = 1'b0;
    for (int b = 0; b < int'(NUM_WB); b++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rs_hit_s[i] = rs_hit_s[i] | (bus_live_s[b] & (rs_tag_r[i] == wb_tag[b*TAG_W +: TAG_W]));
        rt_hit_s[i] = rt_hit_s[i] | (bus_live_s[b] & (rt_tag_r[i] == wb_tag[b*TAG_W +: TAG_W]));
      end
      in_rs_hit_s = in_rs_hit_s | (bus_live_s[b] & (in_rs_tag == wb_tag[b*TAG_W +: TAG_W]));
      in_rt_hit_s = in_rt_hit_s | (bus_live_s[b] & (in_rt_tag == wb_tag[b*TAG_W +: TAG_W]));
    end
  end

  assign free_vec_s  = ~valid_r;
  assign ready_vec_s = valid_r & rs_rdy_r & rt_rdy_r;
  assign free_oh_s   = DEPTH'(lowest_set(IQ_MAX_DEPTH'(free_vec_s)));
  assign sel_idx_s   = IDX_W'(onehot_to_idx(IQ_MAX_DEPTH'(sel_oh_s)));

  assign full        = (count_r == CNT_W'(DEPTH));
  assign empty       = (count_r == {CNT_W{1'b0}});
  assign count       = count_r;
  // Slot freed by a same-cycle issue is not offered to dispatch until the next cycle
  assign in_ready    = ~full;
  assign out_valid_s = |ready_vec_s;
  assign out_valid   = out_valid_s;
  assign ins_fire_s  = in_valid & ~full & ~flush;
  assign iss_fire_s  = out_valid_s & out_ready & ~flush;

  generate
    if (SEL_MODE == SEL_OLDEST) begin : g_oldest
      iq_age_matrix #(
        .DEPTH(DEPTH)
      ) u_age (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (flush),
        .ins_en    (ins_fire_s),
        .ins_oh    (free_oh_s),
        .clr_en    (iss_fire_s),
        .clr_oh    (sel_oh_s),
        .valid_vec (valid_r),
        .rdy_vec   (ready_vec_s),
        .oldest_oh (sel_oh_s)
      );
    end else begin : g_lowest
      assign sel_oh_s = DEPTH'(lowest_set(IQ_MAX_DEPTH'(ready_vec_s)));
    end
  endgenerate

  // Present the selected entry, zeros when nothing is ready
  always_comb begin
    if (out_valid_s) begin
      out_payload = payload_r[sel_idx_s];
      out_rs_tag  = rs_tag_r[sel_idx_s];
      out_rt_tag  = rt_tag_r[sel_idx_s];
    end else begin
      out_payload = {PAYLOAD_W{1'b0}};
      out_rs_tag  = {TAG_W{1'b0}};
      out_rt_tag  = {TAG_W{1'b0}};
    end
  end

  // Entry storage, wakeup, insert and issue
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_r  <= '0;
      rs_rdy_r <= '0;
      rt_rdy_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rs_tag_r[i]  <= '0;
        rt_tag_r[i]  <= '0;
        payload_r[i] <= '0;
      end
    end else if (flush) begin
      valid_r <= '0;
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(ins_fire_s) - CNT_W'(iss_fire_s);
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ins_fire_s && free_oh_s[i]) begin
          valid_r[i]   <= 1'b1;
          rs_rdy_r[i]  <= in_rs_rdy | (in_rs_tag == TAG_W'(TAG_NULL)) | in_rs_hit_s;
          rt_rdy_r[i]  <= in_rt_rdy | (in_rt_tag == TAG_W'(TAG_NULL)) | in_rt_hit_s;
          rs_tag_r[i]  <= in_rs_tag;
          rt_tag_r[i]  <= in_rt_tag;
          payload_r[i] <= in_payload;
        end else begin
          valid_r[i]  <= valid_r[i] & ~(iss_fire_s & sel_oh_s[i]);
          rs_rdy_r[i] <= rs_rdy_r[i] | rs_hit_s[i];
          rt_rdy_r[i] <= rt_rdy_r[i] | rt_hit_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: an in-order list of live instructions models the queue,
// expected issues are queued at handshake time and a separate monitor checks DUT issues.
module tb_issue_queue;

  localparam int DEPTH = 16;
  localparam int PW    = 157;
  localparam int TW    = 6;

  logic          CLK, RESET, flush, in_valid, in_ready, in_rs_rdy, in_rt_rdy;
  logic          out_valid, out_ready, full, empty;
  logic [PW-1:0] in_payload, out_payload;
  logic [TW-1:0] in_rs_tag, in_rt_tag, out_rs_tag, out_rt_tag;
  logic [1:0]    wb_valid;
  logic [11:0]   wb_tag;
  logic [4:0]    count;

  issue_queue dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rs_tag(in_rs_tag), .in_rs_rdy(in_rs_rdy), .in_rt_tag(in_rt_tag), .in_rt_rdy(in_rt_rdy),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rs_tag(out_rs_tag), .out_rt_tag(out_rt_tag),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic [PW-1:0] pl;
    logic [5:0]    rs;
    logic [5:0]    rt;
    bit            rsr;
    bit            rtr;
  } ent_t;

  typedef struct {
    logic [PW-1:0] pl;
    logic [5:0]    rs;
    logic [5:0]    rt;
  } exp_t;

  ent_t mq[$];   // live instructions, oldest first
  exp_t sbq[$];  // expected issues in order

  int n_cmp = 0;
  int n_err = 0;
  int uid   = 1;

  logic       seen_ov, seen_full, seen_inr, seen_empty;
  logic [5:0] seen_rs;
  logic [4:0] seen_cnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit hit(input logic [5:0] tag, input logic [1:0] v, input logic [11:0] t);
    return (tag != 6'd0) && ((v[0] && t[5:0] == tag) || (v[1] && t[11:6] == tag));
  endfunction

  function automatic logic [PW-1:0] new_payload();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    t[15:0] = uid[15:0];
    uid++;
    return t[PW-1:0];
  endfunction

  task automatic idle();
    in_valid = 1'b0; in_payload = '0; in_rs_tag = '0; in_rs_rdy = 1'b0;
    in_rt_tag = '0; in_rt_rdy = 1'b0; wb_valid = '0; wb_tag = '0;
    out_ready = 1'b0; flush = 1'b0;
  endtask

  // One clock cycle: check status, drive inputs, predict issue, then advance the model.
  task automatic step(input bit iv, input logic [5:0] rs, input bit rsr, input logic [5:0] rt,
                      input bit rtr, input logic [1:0] wbv, input logic [11:0] wbt,
                      input bit ordy, input bit fl);
    int            mi;
    int            presz;
    bit            hs;
    logic [PW-1:0] pl;
    ent_t          e;
    @(negedge CLK);
    chk("count", 192'(count), 192'(mq.size()));
    chk("full", 192'(full), 192'(mq.size() == DEPTH));
    chk("empty", 192'(empty), 192'(mq.size() == 0));
    chk("in_ready", 192'(in_ready), 192'(mq.size() < DEPTH));
    pl = new_payload();
    in_valid = iv; in_payload = pl; in_rs_tag = rs; in_rs_rdy = rsr; in_rt_tag = rt;
    in_rt_rdy = rtr; wb_valid = wbv; wb_tag = wbt; out_ready = ordy; flush = fl;
    #1;
    seen_ov = out_valid; seen_rs = out_rs_tag; seen_full = full; seen_inr = in_ready;
    seen_cnt = count; seen_empty = empty;
    mi = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mi < 0 && mq[i].rsr && mq[i].rtr) mi = i;
    end
    chk("out_valid", 192'(out_valid), 192'(mi >= 0));
    if (mi < 0) chk("idle_zero", 192'({out_payload, out_rs_tag, out_rt_tag}), 192'(0));
    hs = (mi >= 0) && ordy && !fl;
    if (hs) sbq.push_back('{mq[mi].pl, mq[mi].rs, mq[mi].rt});
    @(posedge CLK);
    presz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (hs) mq.delete(mi);
      foreach (mq[i]) begin
        if (hit(mq[i].rs, wbv, wbt)) mq[i].rsr = 1'b1;
        if (hit(mq[i].rt, wbv, wbt)) mq[i].rtr = 1'b1;
      end
      if (iv && presz < DEPTH) begin
        e = '{pl, rs, rt, rsr || rs == 6'd0 || hit(rs, wbv, wbt), rtr || rt == 6'd0 || hit(rt, wbv, wbt)};
        mq.push_back(e);
      end
    end
  endtask

  // Monitor: every DUT issue handshake must match the next expected issue
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL issue_unexpected: got payload %0h expected no issue", out_payload);
        end else begin
          x = sbq.pop_front();
          chk("issue_payload", 192'(out_payload), 192'(x.pl));
          chk("issue_rs_tag", 192'(out_rs_tag), 192'(x.rs));
          chk("issue_rt_tag", 192'(out_rt_tag), 192'(x.rt));
        end
      end
    end
  end

  initial begin
    RESET = 1'b0;
    idle();
    repeat (2) @(negedge CLK);
    chk("rst_count", 192'(count), 192'(0));
    chk("rst_empty", 192'(empty), 192'(1));
    chk("rst_full", 192'(full), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    chk("rst_out", 192'({out_valid, out_payload, out_rs_tag, out_rt_tag}), 192'(0));
    #3 RESET = 1'b1;

    // Asynchronous reset in the middle of a run
    repeat (5) step(1'b1, 6'd20, 1'b0, 6'd21, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    @(negedge CLK);
    idle();
    #3 RESET = 1'b0;
    #1;
    chk("midrst_count", 192'(count), 192'(0));
    chk("midrst_empty", 192'(empty), 192'(1));
    chk("midrst_out_valid", 192'(out_valid), 192'(0));
    mq.delete();
    sbq.delete();
    @(negedge CLK);
    #3 RESET = 1'b1;

    // Wakeup one cycle after insert
    step(1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, {6'd0, 6'd7}, 1'b0, 1'b0);
    chk("wake_not_yet", 192'(seen_ov), 192'(0));
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b1, 1'b0);
    chk("wake_valid", 192'(seen_ov), 192'(1));
    chk("wake_rs_tag", 192'(seen_rs), 192'(7));

    // Same-cycle bypass on bus 1
    step(1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 2'b10, {6'd9, 6'd0}, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b1, 1'b0);
    chk("bypass_valid", 192'(seen_ov), 192'(1));
    chk("bypass_rs_tag", 192'(seen_rs), 192'(9));

    // Oldest-first after the oldest entry wakes last
    step(1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    step(1'b1, 6'd4, 1'b1, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    step(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, {6'd0, 6'd3}, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b1, 1'b0);
      chk("age_order", 192'(seen_rs), 192'(3 + k));
    end

    // Full: 17th insert dropped, slot available again the cycle after an issue
    repeat (16) step(1'b1, 6'd10, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    step(1'b1, 6'd11, 1'b1, 6'd0, 1'b0, 2'b01, {6'd0, 6'd10}, 1'b0, 1'b0);
    chk("full_flag", 192'(seen_full), 192'(1));
    chk("full_in_ready", 192'(seen_inr), 192'(0));
    step(1'b1, 6'd11, 1'b1, 6'd0, 1'b0, 2'b00, 12'd0, 1'b1, 1'b0);
    chk("full_dropped", 192'(seen_cnt), 192'(16));
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    chk("full_freed_ready", 192'(seen_inr), 192'(1));
    chk("full_freed_count", 192'(seen_cnt), 192'(15));
    repeat (15) step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b1, 1'b0);

    // Flush beats a same-cycle insert and issue
    repeat (4) step(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    step(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 2'b00, 12'd0, 1'b1, 1'b1);
    chk("flush_pre_count", 192'(seen_cnt), 192'(4));
    chk("flush_pre_valid", 192'(seen_ov), 192'(1));
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    chk("flush_count", 192'(seen_cnt), 192'(0));
    chk("flush_empty", 192'(seen_empty), 192'(1));

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 9) < 7, 6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
           6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           {6'($urandom_range(1, 15)), 6'($urandom_range(0, 15))},
           $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
    end
    step(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 12'd0, 1'b0, 1'b0);
    chk("scoreboard_drained", 192'(sbq.size()), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
